// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle controller: states, instruction
// classes, opcodes, ALU codes and the ALUSrcB / PCSrc mux encodings.
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9
  } state_t;

  typedef enum logic [2:0] {
    CLS_ILLEGAL = 3'd0,
    CLS_LW      = 3'd1,
    CLS_SW      = 3'd2,
    CLS_RTYPE   = 3'd3,
    CLS_NORI    = 3'd4,
    CLS_BLEU    = 3'd5,
    CLS_JR      = 3'd6,
    CLS_JAL     = 3'd7
  } ins_class_t;

  localparam logic [5:0] OP_AND  = 6'b100000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_JR   = 6'b001000;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_NOR  = 6'b100110;
  localparam logic [5:0] OP_NORI = 6'b001110;
  localparam logic [5:0] OP_NOT  = 6'b000100;
  localparam logic [5:0] OP_BLEU = 6'b010000;
  localparam logic [5:0] OP_ROLV = 6'b000000;
  localparam logic [5:0] OP_RORV = 6'b000010;

  localparam logic [4:0] ALU_ADD = 5'b01000;
  localparam logic [4:0] ALU_SUB = 5'b01001;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_CONST4 = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REG    = 2'b11;

endpackage

// File: rtl/ctrl_decode.sv
// Opcode to instruction-class map; anything unrecognised is CLS_ILLEGAL.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OP_W = 6
) (
  input  logic [OP_W-1:0] opcode,
  output ins_class_t      ins_class
);

  always_comb begin
    ins_class = CLS_ILLEGAL;
    case (opcode)
      OP_LW:   ins_class = CLS_LW;
      OP_SW:   ins_class = CLS_SW;
      OP_AND,
      OP_NOR,
      OP_NOT,
      OP_ROLV,
      OP_RORV: ins_class = CLS_RTYPE;
      OP_NORI: ins_class = CLS_NORI;
      OP_BLEU: ins_class = CLS_BLEU;
      OP_JR:   ins_class = CLS_JR;
      OP_JAL:  ins_class = CLS_JAL;
      default: ins_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM. State and latched instruction class are
// registered; strobes are decoded from the current state (and mem_ready/cond).
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int INS_W = 32,
  parameter int OP_W  = 6,
  parameter int ALU_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [INS_W-1:0] ins,
  input  logic             mem_ready,
  input  logic             cond,
  output logic             memRead,
  output logic             memWrite,
  output logic             IorD,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             branchEnable,
  output logic             jumpReg,
  output logic             regDst,
  output logic             regWriteEnable,
  output logic             memToReg,
  output logic             link,
  output logic             ALUSrcA,
  output logic             illegal,
  output logic             done,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       PCSrc,
  output logic [ALU_W-1:0] ALUControl,
  output logic [3:0]       state
);

  logic [OP_W-1:0]  opcode;
  logic [ALU_W-1:0] alu_field;
  logic             unused_ins;
  state_t           state_q;
  ins_class_t       dec_class;
  ins_class_t       cls_q;

  assign opcode    = ins[INS_W-1 -: OP_W];
  assign alu_field = ins[INS_W-1 -: ALU_W];
  // Low instruction bits are datapath fields, not control inputs.
  assign unused_ins = ^ins[INS_W-OP_W-1:0];

  ctrl_decode #(.OP_W(OP_W)) u_decode (
    .opcode    (opcode),
    .ins_class (dec_class)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= FETCH;
      cls_q   <= CLS_ILLEGAL;
    end else begin
      case (state_q)
        FETCH:  if (mem_ready) state_q <= DECODE;
        DECODE: begin
          cls_q <= dec_class;
          case (dec_class)
            CLS_LW, CLS_SW:      state_q <= MEMADR;
            CLS_RTYPE, CLS_NORI: state_q <= EXEC;
            CLS_BLEU:            state_q <= BRANCH;
            CLS_JR, CLS_JAL:     state_q <= JUMP;
            default:             state_q <= FETCH;
          endcase
        end
        MEMADR: state_q <= (cls_q == CLS_SW) ? MEMWR : MEMRD;
        MEMRD:  if (mem_ready) state_q <= MEMWB;
        MEMWR:  if (mem_ready) state_q <= FETCH;
        EXEC:   state_q <= ALUWB;
        default: state_q <= FETCH;
      endcase
    end
  end

  // Outputs are forced to their idle values while reset is high so an
  // aborted instruction never emits a write strobe or done in that cycle.
  always_comb begin
    memRead        = 1'b0;
    memWrite       = 1'b0;
    IorD           = 1'b0;
    IRWrite        = 1'b0;
    PCWrite        = 1'b0;
    branchEnable   = 1'b0;
    jumpReg        = 1'b0;
    regDst         = 1'b0;
    regWriteEnable = 1'b0;
    memToReg       = 1'b0;
    link           = 1'b0;
    ALUSrcA        = 1'b0;
    illegal        = 1'b0;
    done           = 1'b0;
    ALUSrcB        = SRCB_REG;
    PCSrc          = PCSRC_ALU;
    ALUControl     = ALU_W'(ALU_ADD);
    state          = reset ? FETCH : state_q;
    if (!reset) begin
      case (state_q)
        FETCH: begin
          memRead = 1'b1;
          ALUSrcB = SRCB_CONST4;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        DECODE: begin
          ALUSrcB = SRCB_IMM_SH;
          illegal = (dec_class == CLS_ILLEGAL);
        end
        MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
        end
        MEMRD: begin
          memRead = 1'b1;
          IorD    = 1'b1;
        end
        MEMWB: begin
          regWriteEnable = 1'b1;
          memToReg       = 1'b1;
          done           = 1'b1;
        end
        MEMWR: begin
          memWrite = 1'b1;
          IorD     = 1'b1;
          done     = mem_ready;
        end
        EXEC: begin
          ALUSrcA    = 1'b1;
          ALUControl = alu_field;
          ALUSrcB    = (cls_q == CLS_NORI) ? SRCB_IMM : SRCB_REG;
        end
        ALUWB: begin
          regWriteEnable = 1'b1;
          regDst         = (cls_q == CLS_RTYPE);
          done           = 1'b1;
        end
        BRANCH: begin
          ALUSrcA      = 1'b1;
          ALUControl   = ALU_W'(ALU_SUB);
          branchEnable = 1'b1;
          PCSrc        = PCSRC_ALUOUT;
          PCWrite      = cond;
          done         = 1'b1;
        end
        JUMP: begin
          PCWrite = 1'b1;
          done    = 1'b1;
          if (cls_q == CLS_JAL) begin
            PCSrc          = PCSRC_JUMP;
            regWriteEnable = 1'b1;
            link           = 1'b1;
          end else begin
            PCSrc   = PCSRC_REG;
            jumpReg = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: the driver queues a hand-written
// expected output word per cycle, a negedge monitor pops and compares.
module tb_multicycle_control;

  logic        clock;
  logic        reset;
  logic [31:0] ins;
  logic        mem_ready;
  logic        cond;
  logic        memRead, memWrite, IorD, IRWrite, PCWrite, branchEnable, jumpReg;
  logic        regDst, regWriteEnable, memToReg, link, ALUSrcA, illegal, done;
  logic [1:0]  ALUSrcB, PCSrc;
  logic [4:0]  ALUControl;
  logic [3:0]  state;

  localparam int W = 27;
  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           vectors = 0;
  int           miscompares = 0;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BLEU = 6'b010000;
  localparam logic [5:0] JAL = 6'b000011, JR = 6'b001000, NORI = 6'b001110;
  localparam logic [5:0] AND_OP = 6'b100000, BAD = 6'b111111;
  localparam logic [4:0] ADD = 5'b01000, SUB = 5'b01001;

  localparam logic [13:0] MR = 14'h2000, MW = 14'h1000, IORD = 14'h0800;
  localparam logic [13:0] IRW = 14'h0400, PCW = 14'h0200, BE = 14'h0100;
  localparam logic [13:0] JRG = 14'h0080, RDST = 14'h0040, RWE = 14'h0020;
  localparam logic [13:0] M2R = 14'h0010, LNK = 14'h0008, ASA = 14'h0004;
  localparam logic [13:0] ILL = 14'h0002, DN = 14'h0001;

  multicycle_control dut (
    .clock(clock), .reset(reset), .ins(ins), .mem_ready(mem_ready), .cond(cond),
    .memRead(memRead), .memWrite(memWrite), .IorD(IorD), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .branchEnable(branchEnable), .jumpReg(jumpReg),
    .regDst(regDst), .regWriteEnable(regWriteEnable), .memToReg(memToReg),
    .link(link), .ALUSrcA(ALUSrcA), .illegal(illegal), .done(done),
    .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .ALUControl(ALUControl), .state(state)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // driver: apply one cycle of inputs and queue that cycle's expected outputs
  task automatic step(input logic rst, input logic [5:0] op, input logic mr,
                      input logic c, input string tag, input logic [3:0] st,
                      input logic [4:0] alu, input logic [1:0] srcb,
                      input logic [1:0] pcs, input logic [13:0] strb);
    reset     = rst;
    ins       = {op, 26'($urandom)};
    mem_ready = mr;
    cond      = c;
    exp_q.push_back({st, alu, srcb, pcs, strb});
    tag_q.push_back(tag);
    @(posedge clock);
    #1;
  endtask

  task automatic fetch_decode(input logic [5:0] op, input string name);
    step(1'b0, op, 1'b1, 1'b0, {name, "_fetch"}, 4'd0, ADD, 2'b01, 2'b00, MR | IRW | PCW);
    step(1'b0, op, 1'b1, 1'b0, {name, "_decode"}, 4'd1, ADD, 2'b11, 2'b00, 14'h0);
  endtask

  // scoreboard monitor
  always @(negedge clock) begin
    logic [W-1:0] got, e;
    string t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      got = {state, ALUControl, ALUSrcB, PCSrc, memRead, memWrite, IorD, IRWrite,
             PCWrite, branchEnable, jumpReg, regDst, regWriteEnable, memToReg,
             link, ALUSrcA, illegal, done};
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL %s: got %b expected %b", t, got, e);
      end
    end
  end

  initial begin
    reset = 1'b1; ins = '0; mem_ready = 1'b0; cond = 1'b0;
    @(posedge clock);
    #1;
    for (int i = 0; i < 3; i++)
      step(1'b1, LW, 1'b1, 1'b0, "reset", 4'd0, ADD, 2'b00, 2'b00, 14'h0);

    fetch_decode(LW, "lw");
    step(1'b0, LW, 1'b1, 1'b0, "lw_memadr", 4'd2, ADD, 2'b10, 2'b00, ASA);
    step(1'b0, LW, 1'b1, 1'b0, "lw_memrd", 4'd3, ADD, 2'b00, 2'b00, MR | IORD);
    step(1'b0, LW, 1'b1, 1'b0, "lw_memwb", 4'd4, ADD, 2'b00, 2'b00, RWE | M2R | DN);

    fetch_decode(SW, "sw");
    step(1'b0, SW, 1'b1, 1'b0, "sw_memadr", 4'd2, ADD, 2'b10, 2'b00, ASA);
    step(1'b0, SW, 1'b0, 1'b0, "sw_wait1", 4'd5, ADD, 2'b00, 2'b00, MW | IORD);
    step(1'b0, SW, 1'b0, 1'b0, "sw_wait2", 4'd5, ADD, 2'b00, 2'b00, MW | IORD);
    step(1'b0, SW, 1'b1, 1'b0, "sw_memwr", 4'd5, ADD, 2'b00, 2'b00, MW | IORD | DN);

    fetch_decode(BLEU, "bleu0");
    step(1'b0, BLEU, 1'b1, 1'b0, "bleu0_branch", 4'd8, SUB, 2'b00, 2'b01, BE | ASA | DN);
    fetch_decode(BLEU, "bleu1");
    step(1'b0, BLEU, 1'b1, 1'b1, "bleu1_branch", 4'd8, SUB, 2'b00, 2'b01, BE | ASA | PCW | DN);

    fetch_decode(JAL, "jal");
    step(1'b0, JAL, 1'b1, 1'b0, "jal_jump", 4'd9, ADD, 2'b00, 2'b10, PCW | RWE | LNK | DN);
    fetch_decode(JR, "jr");
    step(1'b0, JR, 1'b1, 1'b0, "jr_jump", 4'd9, ADD, 2'b00, 2'b11, JRG | PCW | DN);

    step(1'b0, BAD, 1'b1, 1'b0, "bad_fetch", 4'd0, ADD, 2'b01, 2'b00, MR | IRW | PCW);
    step(1'b0, BAD, 1'b1, 1'b0, "bad_decode", 4'd1, ADD, 2'b11, 2'b00, ILL);

    step(1'b0, NORI, 1'b0, 1'b0, "nori_fetch_wait", 4'd0, ADD, 2'b01, 2'b00, MR);
    fetch_decode(NORI, "nori");
    step(1'b0, NORI, 1'b1, 1'b0, "nori_exec", 4'd6, 5'b00111, 2'b10, 2'b00, ASA);
    step(1'b0, NORI, 1'b1, 1'b0, "nori_aluwb", 4'd7, ADD, 2'b00, 2'b00, RWE | DN);

    fetch_decode(AND_OP, "and");
    step(1'b0, AND_OP, 1'b1, 1'b0, "and_exec", 4'd6, 5'b10000, 2'b00, 2'b00, ASA);
    step(1'b0, AND_OP, 1'b1, 1'b0, "and_aluwb", 4'd7, ADD, 2'b00, 2'b00, RWE | RDST | DN);

    fetch_decode(LW, "lwabort");
    step(1'b0, LW, 1'b1, 1'b0, "lwabort_memadr", 4'd2, ADD, 2'b10, 2'b00, ASA);
    step(1'b0, LW, 1'b0, 1'b0, "lwabort_memrd_wait", 4'd3, ADD, 2'b00, 2'b00, MR | IORD);
    step(1'b1, LW, 1'b1, 1'b0, "lwabort_reset", 4'd0, ADD, 2'b00, 2'b00, 14'h0);
    step(1'b0, LW, 1'b0, 1'b0, "after_abort_fetch", 4'd0, ADD, 2'b01, 2'b00, MR);
    step(1'b0, LW, 1'b1, 1'b0, "after_abort_fetch2", 4'd0, ADD, 2'b01, 2'b00, MR | IRW | PCW);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL provide parameters INS_W (default 32): instruction width; OP_W (6): opcode width; ALU_W (5): ALU control width.
REQ-002 SHALL take opcode = ins[INS_W-1 -: OP_W] and aluField = ins[INS_W-1 -: ALU_W].
REQ-003 clock  in  1  single clock, all state on rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 ins  in  INS_W  IR contents, stable from DECODE until instruction end.
REQ-006 mem_ready  in  1  memory handshake, access completes in a cycle where high.
REQ-007 cond  in  1  ALU branch-condition flag (unsigned a<=b).
REQ-008 Outputs, 1 bit each: memRead, memWrite, IorD, IRWrite, PCWrite, branchEnable, jumpReg, regDst, regWriteEnable, memToReg, link, ALUSrcA, illegal, done.
REQ-009 Outputs, 2 bits each: ALUSrcB (00 reg, 01 const4, 10 imm, 11 imm<<2); PCSrc (00 ALU, 01 ALUOut, 10 jump target, 11 register).
REQ-010 Outputs, wider: ALUControl (ALU_W bits), state (4 bits, current state for debug).

Function
REQ-011 SHALL implement states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, JUMP.
REQ-012 FETCH: memRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUControl=ALU_ADD, PCSrc=00. IRWrite and PCWrite equal mem_ready. Stay until mem_ready=1, then go to DECODE.
REQ-013 DECODE: ALUSrcA=0, ALUSrcB=11, ALUControl=ALU_ADD. Latch the opcode class into a register; it drives all later states.
REQ-014 Transitions out of DECODE: lw/sw->MEMADR; and/nor/not/rolv/rorv/nori->EXEC; bleu->BRANCH; jr/jal->JUMP; any other opcode->FETCH with illegal=1 for exactly that cycle.
REQ-015 Opcodes (package constants): and 100000, lw 100011, sw 101011, jr 001000, jal 000011, nor 100110, nori 001110, not 000100, bleu 010000, rolv 000000, rorv 000010.
REQ-016 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUControl=ALU_ADD. Next state MEMRD for lw, MEMWR for sw.
REQ-017 MEMRD: memRead=1, IorD=1. Hold until mem_ready, then go to MEMWB.
REQ-018 MEMWB: regWriteEnable=1, memToReg=1, regDst=0, done=1. Next state FETCH.
REQ-019 MEMWR: memWrite=1, IorD=1. Hold until mem_ready; in that cycle done=1 and next state is FETCH.
REQ-020 EXEC: ALUSrcA=1, ALUControl=aluField. ALUSrcB=10 for nori, otherwise 00. Next state ALUWB.
REQ-021 ALUWB: regWriteEnable=1, memToReg=0, done=1. regDst=1 for R-type, 0 for nori. Next state FETCH.
REQ-022 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUControl=ALU_SUB, branchEnable=1, PCSrc=01, PCWrite=cond, done=1. Next state FETCH.
REQ-023 JUMP, jal: PCSrc=10, PCWrite=1, regWriteEnable=1, link=1.
REQ-024 JUMP, jr: PCSrc=11, jumpReg=1, PCWrite=1.
REQ-025 JUMP, both: done=1, next state FETCH.
REQ-026 Any output not listed for a state SHALL be 0 in that state; ALUControl defaults to ALU_ADD.
REQ-027 Minimum latency with mem_ready tied high: lw 5, sw 4, ALU ops 4, bleu 3, jr/jal 3 cycles. Each mem_ready=0 cycle in FETCH/MEMRD/MEMWR adds one cycle.
REQ-028 memWrite and regWriteEnable SHALL never be high in the same cycle.
REQ-029 done SHALL pulse exactly once per legal instruction and never for an illegal one.

Reset
REQ-030 While reset=1, every output SHALL be 0, except state=FETCH and ALUControl=ALU_ADD.
REQ-031 After reset, the first cycle with reset=0 SHALL be in FETCH.
REQ-032 Reset mid-instruction (including during a memory wait) SHALL abort it, with no write strobe in the reset cycle and no done pulse.

Structure
REQ-033 Package ctrl_pkg SHALL hold the state enum, opcode constants, ALU_ADD/ALU_SUB, and the ALUSrcB/PCSrc encodings.
REQ-034 A combinational sub-module ctrl_decode SHALL map opcode to the instruction class (including illegal); it is instantiated once.

Verification
REQ-035 Reset held 3 cycles with ins=lw, then released -> all strobes 0 during reset; FETCH on the first free cycle; lw sequence follows.
REQ-036 lw (100011), mem_ready=1 -> FETCH,DECODE,MEMADR,MEMRD,MEMWB; one done; regWriteEnable with memToReg=1 in cycle 5.
REQ-037 sw, mem_ready low for 2 cycles in MEMWR -> memWrite high 3 cycles; done only on the ready cycle; total 6 cycles.
REQ-038 bleu, run twice with cond=0 then cond=1 -> PCWrite 0 then 1 in BRANCH, PCSrc=01; jal -> PCSrc=10, link=1, regWriteEnable=1.
REQ-039 Opcode 111111 -> illegal pulse in DECODE, no done, FETCH next; reset asserted during a MEMRD wait -> FETCH next, no regWriteEnable.
REQ-040 nori (001110) -> EXEC with ALUSrcB=10, ALUControl=00111; ALUWB with regDst=0.
